shift_reg_universal: RTL and testbench



---
 rtl/shift_reg_pkg.sv | 11 +
 rtl/shift_frame_cnt.sv | 44 ++++
 rtl/shift_reg_universal.sv | 89 ++++++++
 tb/tb_shift_reg_universal.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg
//   Shared constants for the universal shift register.
//   MODE_* : encoding of the 2-bit mode input (full decode).
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_FWD  = 2'b01;
  localparam logic [1:0] MODE_REV  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_frame_cnt.sv
// shift_frame_cnt
//   Frame counter for the universal shift register. Raises frame_done for one
//   cycle after every DEPTH-th shift, counted since the last clear or load.
//   Ports:
//     clk        rising-edge clock
//     clear      synchronous active-high reset
//     shift      a forward or reverse shift happens on this edge
//     load       a parallel load happens on this edge (restarts the frame)
//     frame_done one-cycle pulse after the wrapping shift
module shift_frame_cnt #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic shift,
  input  logic load,
  output logic frame_done
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEPTH - 1);

  // Down-counter of shifts remaining in the current frame; terminal count 0
  // marks the wrapping shift.
  logic [CW-1:0] remain;

  always_ff @(posedge clk) begin
    if (clear || load) begin
      remain     <= RELOAD;
      frame_done <= 1'b0;
    end else if (shift) begin
      if (remain == '0) begin
        remain     <= RELOAD;
        frame_done <= 1'b1;
      end else begin
        remain     <= remain - 1'b1;
        frame_done <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_reg_universal.sv
// shift_reg_universal
//   DEPTH-stage, WIDTH-bit-per-stage universal shift register: hold, forward
//   shift, reverse shift, parallel load, parallel read.
//   Build option: define SHIFT_FRAME_CNT_EN to implement the frame counter;
//   otherwise frame_done is tied low.
//   Ports:
//     clk, clear        clock, synchronous active-high reset
//     en                clock enable (low = hold everything)
//     mode              00 hold, 01 forward, 10 reverse, 11 load
//     sin_f / sin_r     serial inputs into stage 0 / stage DEPTH-1
//     pin / pout        parallel data, stage i at [i*WIDTH +: WIDTH]
//     sout_f / sout_r   stage DEPTH-1 / stage 0
//     frame_done        pulse after every DEPTH-th shift
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       sin_f,
  input  logic [WIDTH-1:0]       sin_r,
  input  logic [DEPTH*WIDTH-1:0] pin,
  output logic [WIDTH-1:0]       sout_f,
  output logic [WIDTH-1:0]       sout_r,
  output logic [DEPTH*WIDTH-1:0] pout,
  output logic                   frame_done
);

  logic [WIDTH-1:0] q [DEPTH];
  logic [WIDTH-1:0] d [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] fwd_src;
    logic [WIDTH-1:0] rev_src;

    if (gi == 0) begin : g_head
      assign fwd_src = sin_f;
    end else begin : g_mid_f
      assign fwd_src = q[gi-1];
    end

    if (gi == DEPTH - 1) begin : g_tail
      assign rev_src = sin_r;
    end else begin : g_mid_r
      assign rev_src = q[gi+1];
    end

    assign d[gi] = (mode == MODE_FWD)  ? fwd_src :
                   (mode == MODE_REV)  ? rev_src :
                   (mode == MODE_LOAD) ? pin[gi*WIDTH +: WIDTH] :
                                         q[gi];

    assign pout[gi*WIDTH +: WIDTH] = q[gi];
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= d[i];
    end
  end

  assign sout_f = q[DEPTH-1];
  assign sout_r = q[0];

`ifdef SHIFT_FRAME_CNT_EN
  logic do_shift;
  logic do_load;

  assign do_shift = en && ((mode == MODE_FWD) || (mode == MODE_REV));
  assign do_load  = en && (mode == MODE_LOAD);

  shift_frame_cnt #(.DEPTH(DEPTH)) u_frame_cnt (
    .clk        (clk),
    .clear      (clear),
    .shift      (do_shift),
    .load       (do_load),
    .frame_done (frame_done)
  );
`else
  assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_universal.sv
module tb_shift_reg_universal;

  localparam int D = 4;
  localparam int W = 8;

`ifdef SHIFT_FRAME_CNT_EN
  localparam bit FD_ON = 1'b1;
`else
  localparam bit FD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- DUT with WIDTH=1 (serialiser test) ----------------
  logic         c1_clear = 1'b1, c1_en = 1'b1, c1_sin_f = 1'b0, c1_sin_r = 1'b0;
  logic [1:0]   c1_mode = 2'b00;
  logic [D-1:0] c1_pin = '0;
  logic         c1_sout_f, c1_sout_r, c1_fd;
  logic [D-1:0] c1_pout;

  shift_reg_universal #(.WIDTH(1), .DEPTH(D)) u_dut1 (
    .clk(clk), .clear(c1_clear), .en(c1_en), .mode(c1_mode),
    .sin_f(c1_sin_f), .sin_r(c1_sin_r), .pin(c1_pin),
    .sout_f(c1_sout_f), .sout_r(c1_sout_r), .pout(c1_pout), .frame_done(c1_fd)
  );

  // ---------------- DUT with WIDTH=8 ----------------
  logic           d_clear = 1'b1, d_en = 1'b1;
  logic [1:0]     d_mode = 2'b00;
  logic [W-1:0]   d_sf = '0, d_sr = '0;
  logic [D*W-1:0] d_pin = '0;
  logic [W-1:0]   sout_f8, sout_r8;
  logic [D*W-1:0] pout8;
  logic           fd8;

  shift_reg_universal #(.WIDTH(W), .DEPTH(D)) u_dut8 (
    .clk(clk), .clear(d_clear), .en(d_en), .mode(d_mode),
    .sin_f(d_sf), .sin_r(d_sr), .pin(d_pin),
    .sout_f(sout_f8), .sout_r(sout_r8), .pout(pout8), .frame_done(fd8)
  );

  // Reference model: stages as a plain array, frame tracked as a count of
  // shifts since the last clear/load; a frame ends every D shifts.
  logic [W-1:0] m_stage [D];
  int           m_shifts;
  bit           m_fd;

  task automatic model_update();
    if (d_clear) begin
      for (int i = 0; i < D; i++) m_stage[i] = '0;
      m_shifts = 0;
      m_fd = 0;
    end else if (!d_en || d_mode == 2'b00) begin
      m_fd = 0;
    end else if (d_mode == 2'b11) begin
      for (int i = 0; i < D; i++) m_stage[i] = d_pin[i*W +: W];
      m_shifts = 0;
      m_fd = 0;
    end else begin
      if (d_mode == 2'b01) begin
        for (int i = D-1; i > 0; i--) m_stage[i] = m_stage[i-1];
        m_stage[0] = d_sf;
      end else begin
        for (int i = 0; i < D-1; i++) m_stage[i] = m_stage[i+1];
        m_stage[D-1] = d_sr;
      end
      m_shifts++;
      m_fd = (m_shifts % D) == 0;
    end
  endtask

  task automatic cyc8();
    logic [D*W-1:0] exp_pout;
    model_update();
    @(posedge clk);
    #1;
    for (int i = 0; i < D; i++) exp_pout[i*W +: W] = m_stage[i];
    check("pout8",   64'(pout8),   64'(exp_pout));
    check("sout_f8", 64'(sout_f8), 64'(m_stage[D-1]));
    check("sout_r8", 64'(sout_r8), 64'(m_stage[0]));
    check("fd8",     64'(fd8),     64'(FD_ON & m_fd));
  endtask

  task automatic drive(input logic clr, input logic e, input logic [1:0] md,
                       input logic [W-1:0] sf, input logic [W-1:0] sr,
                       input logic [D*W-1:0] p);
    d_clear = clr; d_en = e; d_mode = md; d_sf = sf; d_sr = sr; d_pin = p;
    cyc8();
  endtask

  typedef struct {
    logic         clear;
    logic [1:0]   mode;
    logic         sin_f;
    logic         exp_sout_f;
    logic [D-1:0] exp_pout;
    logic         exp_fd;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [7:0] rev_exp [4];

    // Serialiser: clear twice, then 1,0,1,0 forward and three more zeros.
    vecs[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[1]  = '{1'b1, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[2]  = '{1'b0, 2'b01, 1'b1, 1'b0, 4'b0001, 1'b0};
    vecs[3]  = '{1'b0, 2'b01, 1'b0, 1'b0, 4'b0010, 1'b0};
    vecs[4]  = '{1'b0, 2'b01, 1'b1, 1'b0, 4'b0101, 1'b0};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 1'b1, 4'b1010, FD_ON};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 1'b0, 4'b0100, 1'b0};
    vecs[7]  = '{1'b0, 2'b01, 1'b0, 1'b1, 4'b1000, 1'b0};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0};

    for (int k = 0; k < 11; k++) begin
      c1_clear = vecs[k].clear;
      c1_mode  = vecs[k].mode;
      c1_sin_f = vecs[k].sin_f;
      @(posedge clk);
      #1;
      check($sformatf("ser%0d_pout", k),   64'(c1_pout),   64'(vecs[k].exp_pout));
      check($sformatf("ser%0d_sout_f", k), 64'(c1_sout_f), 64'(vecs[k].exp_sout_f));
      check($sformatf("ser%0d_sout_r", k), 64'(c1_sout_r), 64'(vecs[k].exp_pout[0]));
      check($sformatf("ser%0d_fd", k),     64'(c1_fd),     64'(vecs[k].exp_fd));
    end

    // Reset state of the wide instance.
    drive(1'b1, 1'b1, 2'b00, 8'h00, 8'h00, '0);
    drive(1'b1, 1'b0, 2'b01, 8'hFF, 8'hFF, '1);
    check("rst_pout8", 64'(pout8), 64'd0);

    // Deserialise by reverse shifting a loaded word out of stage 0.
    rev_exp[0] = 8'hBB; rev_exp[1] = 8'hCC; rev_exp[2] = 8'hDD; rev_exp[3] = 8'h00;
    drive(1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 32'hDDCCBBAA);
    check("load_sout_r", 64'(sout_r8), 64'hAA);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 2'b10, 8'h00, 8'h00, '0);
      check($sformatf("rev%0d_sout_r", k), 64'(sout_r8), 64'(rev_exp[k]));
    end
    check("rev_pout_zero", 64'(pout8), 64'd0);
    check("rev_fd", 64'(fd8), 64'(FD_ON));

    // Enable low holds data and frame position.
    drive(1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 32'h12345678);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 2'b01, 8'hA5, 8'h5A, 32'hFFFFFFFF);
      check($sformatf("hold%0d_pout", k), 64'(pout8), 64'h12345678);
      check($sformatf("hold%0d_fd", k), 64'(fd8), 64'd0);
    end
    drive(1'b0, 1'b1, 2'b00, 8'hA5, 8'h5A, 32'hFFFFFFFF);
    check("mode_hold_pout", 64'(pout8), 64'h12345678);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 2'b01, 8'(k + 1), 8'h00, '0);
      check($sformatf("en_shift%0d_fd", k), 64'(fd8), (k == 3) ? 64'(FD_ON) : 64'd0);
    end
    check("en_shift_pout", 64'(pout8), 64'h01020304);

    // Clear mid-frame restarts the frame.
    drive(1'b0, 1'b1, 2'b01, 8'h11, 8'h00, '0);
    drive(1'b0, 1'b1, 2'b01, 8'h22, 8'h00, '0);
    drive(1'b1, 1'b1, 2'b01, 8'h33, 8'h00, '0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, (k % 2 == 0) ? 2'b01 : 2'b10, 8'h44, 8'h55, '0);
      check($sformatf("clr_shift%0d_fd", k), 64'(fd8), (k == 3) ? 64'(FD_ON) : 64'd0);
    end

    // Load restarts the frame.
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 2'b01, 8'h66, 8'h00, '0);
    drive(1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 32'hCAFEF00D);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 2'b10, 8'h00, 8'h77, '0);
      check($sformatf("ld_shift%0d_fd", k), 64'(fd8), (k == 3) ? 64'(FD_ON) : 64'd0);
    end

    // Back-to-back frames.
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 2'b01, 8'(k), 8'h00, '0);
      check($sformatf("b2b%0d_fd", k), 64'(fd8), ((k % 4) == 3) ? 64'(FD_ON) : 64'd0);
    end

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 32'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
